// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline front end: default address width,
// the nop encoding, the sequential fetch step and the IF/ID bundle type.
package mips_pkg;

  localparam int unsigned DEF_ADDR_W = 32;
  localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;
  localparam int unsigned PC_STEP    = 4;

  // Contents of the IF/ID pipeline register.
  typedef struct packed {
    logic [31:0]           instr;
    logic [DEF_ADDR_W-1:0] pc_plus4;
    logic                  valid;
  } ifid_t;

endpackage

// File: rtl/fetch_stage_pc_register.sv
// Program counter with next-PC selection.
// Priority: reset, jump, taken branch, stall (hold), sequential PC+4.
// Redirect targets are forced word-aligned; PC+4 wraps silently.
module pc_register
  import mips_pkg::*;
#(
  parameter int unsigned          ADDR_W   = DEF_ADDR_W,
  parameter logic [ADDR_W-1:0]    RESET_PC = '0
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_stall,
  input  logic              i_branch_taken,
  input  logic [ADDR_W-1:0] i_branch_target,
  input  logic              i_jump,
  input  logic [ADDR_W-1:0] i_jump_target,
  output logic [ADDR_W-1:0] o_pc,
  output logic [ADDR_W-1:0] o_pc_plus4
);

  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_pc_next;
  logic [ADDR_W-1:0] w_pc_plus4;

  assign w_pc_plus4 = r_pc + ADDR_W'(PC_STEP);

  // Select the next PC; a redirect wins over a stall so it is never lost.
  always_comb begin
    w_pc_next = r_pc;
    if (i_jump) begin
      w_pc_next = {i_jump_target[ADDR_W-1:2], 2'b00};
    end else if (i_branch_taken) begin
      w_pc_next = {i_branch_target[ADDR_W-1:2], 2'b00};
    end else if (i_stall) begin
      w_pc_next = r_pc;
    end else begin
      w_pc_next = w_pc_plus4;
    end
  end

  // PC flop with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_pc <= RESET_PC;
    end else begin
      r_pc <= w_pc_next;
    end
  end

  assign o_pc       = r_pc;
  assign o_pc_plus4 = w_pc_plus4;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: drives the PC to instruction memory and captures
// the returned word plus PC+4 into the IF/ID register, counting every valid
// instruction handed to decode.
// Optional macro FETCH_DELAY_SLOT_EN: when defined, a redirect does not
// flush IF/ID; the instruction being fetched (the delay slot) is kept.
module fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned ADDR_W   = DEF_ADDR_W
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Stall,
  input  logic              BranchTaken,
  input  logic [ADDR_W-1:0] BranchTarget,
  input  logic              Jump,
  input  logic [ADDR_W-1:0] JumpTarget,
  output logic [ADDR_W-1:0] InstrAddress,
  input  logic [31:0]       InstrData,
  output logic [31:0]       Instruction_ID,
  output logic [ADDR_W-1:0] PCPlus4_ID,
  output logic              Valid_ID,
  output logic [31:0]       FetchCount
);

  logic [ADDR_W-1:0] w_pc;
  logic [ADDR_W-1:0] w_pc_plus4;
  logic              w_flush;
  ifid_t             r_ifid;
  logic [31:0]       r_fetch_count;

  pc_register #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC[ADDR_W-1:0])
  ) u_pc_register (
    .i_clk           (Clk),
    .i_reset         (Reset),
    .i_stall         (Stall),
    .i_branch_taken  (BranchTaken),
    .i_branch_target (BranchTarget),
    .i_jump          (Jump),
    .i_jump_target   (JumpTarget),
    .o_pc            (w_pc),
    .o_pc_plus4      (w_pc_plus4)
  );

`ifdef FETCH_DELAY_SLOT_EN
  // The delay-slot instruction is architecturally executed, so never flush.
  assign w_flush = 1'b0;
`else
  // Any redirect squashes the wrong-path instruction, even during a stall.
  assign w_flush = Jump | BranchTaken;
`endif

  // IF/ID register and delivered-instruction counter: flush, hold or load.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_ifid        <= '{instr: NOP_INSTR, pc_plus4: '0, valid: 1'b0};
      r_fetch_count <= 32'd0;
    end else if (w_flush) begin
      r_ifid        <= '{instr: NOP_INSTR, pc_plus4: '0, valid: 1'b0};
      r_fetch_count <= r_fetch_count;
    end else if (Stall) begin
      r_ifid        <= r_ifid;
      r_fetch_count <= r_fetch_count;
    end else begin
      r_ifid        <= '{instr: InstrData, pc_plus4: w_pc_plus4, valid: 1'b1};
      r_fetch_count <= r_fetch_count + 32'd1;
    end
  end

  assign InstrAddress   = w_pc;
  assign Instruction_ID = r_ifid.instr;
  assign PCPlus4_ID     = r_ifid.pc_plus4;
  assign Valid_ID       = r_ifid.valid;
  assign FetchCount     = r_fetch_count;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized
// control inputs, compared against a behavioural model of the fetch rules.
module tb_fetch_stage;

`ifdef FETCH_DELAY_SLOT_EN
  localparam bit DELAY_SLOT = 1'b1;
`else
  localparam bit DELAY_SLOT = 1'b0;
`endif

  logic        Clk = 1'b0;
  logic        Reset, Stall, BranchTaken, Jump;
  logic [31:0] BranchTarget, JumpTarget;
  logic [31:0] InstrAddress, InstrData, Instruction_ID, PCPlus4_ID, FetchCount;
  logic        Valid_ID;

  int n_vec = 0;
  int n_bad = 0;

  // model state
  logic [31:0] m_pc, m_instr, m_p4, m_count;
  logic        m_valid;

  always #5 Clk = ~Clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a >> 2) * 32'd3;
  endfunction

  assign InstrData = mem_word(InstrAddress);

  fetch_stage dut (
    .Clk(Clk), .Reset(Reset), .Stall(Stall),
    .BranchTaken(BranchTaken), .BranchTarget(BranchTarget),
    .Jump(Jump), .JumpTarget(JumpTarget),
    .InstrAddress(InstrAddress), .InstrData(InstrData),
    .Instruction_ID(Instruction_ID), .PCPlus4_ID(PCPlus4_ID),
    .Valid_ID(Valid_ID), .FetchCount(FetchCount)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Apply one cycle of inputs, advance the model, compare after the edge.
  task automatic step(input logic rst, input logic stall, input logic br,
                      input logic [31:0] bt, input logic j, input logic [31:0] jt);
    logic [31:0] fetched, seq;
    bit          redirect;
    Reset = rst; Stall = stall; BranchTaken = br; BranchTarget = bt;
    Jump = j; JumpTarget = jt;
    #1;
    chk("addr_pre", InstrAddress, m_pc);
    @(posedge Clk);
    if (rst) begin
      m_pc = 32'h0; m_instr = 32'h0; m_p4 = 32'h0; m_valid = 1'b0; m_count = 32'h0;
    end else begin
      fetched  = mem_word(m_pc);
      seq      = m_pc + 32'd4;
      redirect = j || br;
      if (redirect && !DELAY_SLOT) begin
        m_instr = 32'h0; m_p4 = 32'h0; m_valid = 1'b0;
      end else if (!stall) begin
        m_instr = fetched; m_p4 = seq; m_valid = 1'b1; m_count = m_count + 32'd1;
      end
      if (j)          m_pc = jt & ~32'd3;
      else if (br)    m_pc = bt & ~32'd3;
      else if (!stall) m_pc = seq;
    end
    #1;
    chk("pc",    InstrAddress,   m_pc);
    chk("instr", Instruction_ID, m_instr);
    chk("pc4",   PCPlus4_ID,     m_p4);
    chk("valid", {31'd0, Valid_ID}, {31'd0, m_valid});
    chk("count", FetchCount,     m_count);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    m_pc = 32'h0; m_instr = 32'h0; m_p4 = 32'h0; m_valid = 1'b0; m_count = 32'h0;
    Reset = 1'b1; Stall = 1'b0; BranchTaken = 1'b0; Jump = 1'b0;
    BranchTarget = 32'd0; JumpTarget = 32'd0;
    @(posedge Clk);
    #1;
    step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    chk("rst_addr",  InstrAddress, 32'h0);
    chk("rst_valid", {31'd0, Valid_ID}, 32'd0);
    chk("rst_count", FetchCount, 32'd0);

    // free run to PC = 8, then stall two cycles
    idle(); idle();
    step(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
    step(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
    chk("stall_addr",  InstrAddress, 32'h8);
    chk("stall_instr", Instruction_ID, 32'd3);
    chk("stall_pc4",   PCPlus4_ID, 32'h8);
    chk("stall_count", FetchCount, 32'd2);
    idle();
    chk("resume_instr", Instruction_ID, 32'd6);

    // taken branch at PC = 12 to 0x40
    step(1'b0, 1'b0, 1'b1, 32'h40, 1'b0, 32'd0);
    chk("br_addr", InstrAddress, 32'h40);
`ifdef FETCH_DELAY_SLOT_EN
    chk("br_slot_instr", Instruction_ID, 32'd9);
    chk("br_slot_valid", {31'd0, Valid_ID}, 32'd1);
`else
    chk("br_flush_valid", {31'd0, Valid_ID}, 32'd0);
    chk("br_flush_instr", Instruction_ID, 32'd0);
`endif
    idle();
    chk("br_target_instr", Instruction_ID, 32'd48);
    chk("br_target_valid", {31'd0, Valid_ID}, 32'd1);

    // jump + branch + stall together: jump wins
    step(1'b0, 1'b1, 1'b1, 32'h40, 1'b1, 32'h80);
    chk("jb_addr", InstrAddress, 32'h80);
`ifndef FETCH_DELAY_SLOT_EN
    chk("jb_flush_valid", {31'd0, Valid_ID}, 32'd0);
`endif

    // misaligned target
    step(1'b0, 1'b0, 1'b1, 32'h43, 1'b0, 32'd0);
    chk("align_addr", InstrAddress, 32'h40);

    // reset mid-stall
    step(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
    step(1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
    chk("rst_stall_addr",  InstrAddress, 32'h0);
    chk("rst_stall_valid", {31'd0, Valid_ID}, 32'd0);
    chk("rst_stall_count", FetchCount, 32'd0);

    // PC wrap at the top of the address space
    step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'hFFFF_FFFC);
    idle();
    chk("wrap_addr", InstrAddress, 32'h0);
    chk("wrap_pc4",  PCPlus4_ID, 32'h0);

    // randomized control traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 63) == 0),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 7) == 0), $urandom(),
           ($urandom_range(0, 9) == 0), $urandom());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage of the single-issue MIPS pipeline.
- Holds the program counter and drives the word-aligned fetch address into the combinational instruction memory.
- Captures the returned instruction together with PC+4 into the IF/ID pipeline register.
- Applies stall, branch/jump redirect and flush requests coming from the hazard unit and the later pipeline stages.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.
ADDR_W, 32, width of PC and address buses.

Ports:
Clk  input  1  pipeline clock; all state updates on rising edge.
Reset  input  1  synchronous, active-high reset.
Stall  input  1  hazard-unit hold: freeze the PC and the IF/ID register.
BranchTaken  input  1  branch resolved taken this cycle.
BranchTarget  input  ADDR_W  branch destination address.
Jump  input  1  j/jal/jr redirect this cycle.
JumpTarget  input  ADDR_W  jump destination address.
InstrAddress  output  ADDR_W  fetch address to instruction memory; equals PC (combinational from the PC register).
InstrData  input  32  instruction returned combinationally by instruction memory.
Instruction_ID  output  32  IF/ID registered instruction.
PCPlus4_ID  output  ADDR_W  IF/ID registered PC+4 of that instruction.
Valid_ID  output  1  IF/ID holds a real instruction (0 = bubble).
FetchCount  output  32  count of valid instructions delivered to ID.

Behaviour:
- Reset (synchronous, sampled at the rising Clk edge)
  - PC <= RESET_PC.
  - Instruction_ID <= 32'h0 (sll $0,$0,0 = nop).
  - PCPlus4_ID <= 0; Valid_ID <= 0; FetchCount <= 0.
  - Reset overrides every other input.
- Fetch latency: the instruction at PC appears on Instruction_ID one edge after PC is presented; InstrAddress is never registered separately.
- Next-PC priority (highest first):
  - Reset.
  - Jump -> JumpTarget.
  - BranchTaken -> BranchTarget.
  - Stall -> PC held.
  - Otherwise PC+4.
- Redirects override Stall for the PC: a redirect is never lost while a stall is in progress.
- Jump and BranchTaken together: Jump wins; no error is flagged.
- Target bits [1:0] are forced to 0 when loaded into the PC.
- PC+4 wraps modulo 2^ADDR_W with no flag.
- IF/ID register, evaluated in this order:
  - Redirect (Jump or BranchTaken), without FETCH_DELAY_SLOT_EN: flush. Instruction_ID <= 0, Valid_ID <= 0, PCPlus4_ID <= 0. Applies even when Stall is high.
  - Else Stall: hold all IF/ID fields unchanged.
  - Else: Instruction_ID <= InstrData, PCPlus4_ID <= PC+4, Valid_ID <= 1.
- FetchCount increments by 1 on each edge where IF/ID loads with Valid_ID <= 1; it wraps at 2^32.
- No further state machine; the state is exactly PC, the IF/ID fields and FetchCount.

Optional Feature:
Macro FETCH_DELAY_SLOT_EN.
- Defined: MIPS branch-delay-slot semantics.
  - On a redirect, IF/ID loads the instruction currently being fetched (the delay slot) normally, unless Stall is high, in which case IF/ID holds.
  - The PC still takes the target.
- Undefined: a redirect flushes IF/ID to a bubble as described in Behaviour.

Decomposition:
- Shared package mips_pkg:
  - NOP_INSTR = 32'h0000_0000.
  - PC_STEP = 4.
  - ADDR_W default.
  - Typedef for the IF/ID bundle {instr, pc_plus4, valid}.
- One natural sub-module, pc_register: the PC flop with next-PC priority mux.
- The IF/ID register and FetchCount stay in fetch_stage.

Test Plan:
- Reset then 4 free-running cycles, memory[i] = i*3 -> InstrAddress 0,4,8,12. Instruction_ID 0,3,6,9 one edge later. Valid_ID 1 from the first post-reset edge. FetchCount = 4.
- Stall high 2 cycles at PC = 8 -> InstrAddress stays 8. Instruction_ID holds 3 and PCPlus4_ID holds 8. FetchCount unchanged. Fetch resumes with 6.
- BranchTaken with BranchTarget = 32'h40 at PC = 12, macro undefined -> next InstrAddress = 0x40, Valid_ID = 0 for one cycle, then Instruction_ID = memory[16] = 48.
- Jump (target 0x80) and BranchTaken (target 0x40) together, Stall also high -> PC = 0x80 and IF/ID flushed.
- Target 32'h43 -> PC = 0x40. Reset asserted mid-stall -> PC = RESET_PC, Valid_ID = 0, FetchCount = 0 next edge.
- FETCH_DELAY_SLOT_EN defined, branch at PC = 12 to 0x40 -> Instruction_ID = 9 (delay slot, Valid_ID = 1), then memory[16] = 48.
